// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: one buffered write
// (destination register plus value) and the register address width.
package rf_wr_pkg;

    localparam int RF_ADDR_W = 5;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [31:0]          data;
    } rf_wr_t;

    function automatic logic [31:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Writeback, long-latency and register-file write signals of the shared write port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline.
interface rf_wport_arbiter_if;
    import rf_wr_pkg::*;

    logic                 wb_valid;
    logic                 wb_wen;
    logic [RF_ADDR_W-1:0] wb_rd;
    logic [31:0]          wb_data;
    logic                 wb_stall;
    logic                 lu_valid;
    logic                 lu_ready;
    logic [RF_ADDR_W-1:0] lu_rd;
    logic [31:0]          lu_data;
    logic                 rf_wen;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 lu_pending;
    logic [31:0]          pend_mask;
    logic [3:0]           fifo_count;

    modport slave (
        input  wb_valid, wb_wen, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        output wb_stall, lu_ready, rf_wen, rf_waddr, rf_wdata,
               lu_pending, pend_mask, fifo_count
    );

    modport master (
        output wb_valid, wb_wen, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        input  wb_stall, lu_ready, rf_wen, rf_waddr, rf_wdata,
               lu_pending, pend_mask, fifo_count
    );

endinterface

// File: rtl/rf_wport_arbiter_fifo.sv
// Small FIFO of buffered register writes, with an explicit occupancy count and a
// per-entry valid vector so the destination of every buffered write is visible.
module rf_wr_fifo
    import rf_wr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                push,
    input  rf_wr_t                              push_data,
    input  logic                                pop,
    output rf_wr_t                              head,
    output logic [3:0]                          count,
    output logic                                full,
    output logic                                empty,
    output logic [DEPTH-1:0]                    ent_vld,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]     ent_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_wr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 4'd0;
            ent_vld <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + 4'(do_push) - 4'(do_pop);
            // Push and pop never share a slot: that needs a FIFO both empty and full.
            if (do_pop)  ent_vld[rd_ptr] <= 1'b0;
            if (do_push) ent_vld[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between writeback and buffered long-latency results.
// Optional starvation guard: define RF_STARVE_GUARD_EN.
module rf_wport_arbiter
    import rf_wr_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    rf_wport_arbiter_if.slave   bus
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
        $error("rf_wport_arbiter: FIFO_DEPTH must be 2/4/8 and STARVE_LIMIT 1..15");
    end

    logic                                wb_req;
    logic                                force_grant;
    logic                                push;
    logic                                pop;
    logic                                full;
    logic                                empty;
    rf_wr_t                              head;
    logic [3:0]                          count;
    logic [FIFO_DEPTH-1:0]               ent_vld;
    logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0] ent_rd;

    assign wb_req = bus.wb_valid & bus.wb_wen & (bus.wb_rd != '0);

    // Ready depends only on stored occupancy, never on this cycle's dequeue.
    assign bus.lu_ready = ~full & ~reset;
    assign push         = bus.lu_valid & bus.lu_ready & (bus.lu_rd != '0);
    assign pop          = ~empty & (force_grant | ~wb_req) & ~reset;

    rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ('{rd: bus.lu_rd, data: bus.lu_data}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd)
    );

`ifdef RF_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)               starve_cnt <= 4'd0;
        else if (empty || pop)   starve_cnt <= 4'd0;
        else                     starve_cnt <= starve_cnt + 4'd1;
    end

    assign force_grant = ~empty & (starve_cnt == 4'(STARVE_LIMIT));
`else
    assign force_grant = 1'b0;
`endif

    assign bus.wb_stall   = force_grant & ~reset;
    assign bus.lu_pending = ~empty;
    assign bus.fifo_count = count;

    always_comb begin
        bus.rf_wen   = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (!reset) begin
            if (pop) begin
                bus.rf_wen   = 1'b1;
                bus.rf_waddr = head.rd;
                bus.rf_wdata = head.data;
            end else if (wb_req) begin
                bus.rf_wen   = 1'b1;
                bus.rf_waddr = bus.wb_rd;
                bus.rf_wdata = bus.wb_data;
            end
        end
    end

    always_comb begin
        bus.pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i]) bus.pend_mask = bus.pend_mask | rd_onehot(ent_rd[i]);
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write-port rules.
module tb_rf_wport_arbiter;
    import rf_wr_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef RF_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    rf_wport_arbiter_if ifc ();

    rf_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    // Reference model: buffered results in arrival order plus consecutive denied cycles.
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t m_q[$];
    int   m_denied = 0;

    function automatic bit m_wb_req();
        return ifc.wb_valid && ifc.wb_wen && (ifc.wb_rd != 5'd0);
    endfunction
    function automatic bit m_forced();
        return GUARD && (m_q.size() != 0) && (m_denied == LIMIT);
    endfunction
    function automatic bit m_pop();
        return (m_q.size() != 0) && (m_forced() || !m_wb_req());
    endfunction
    function automatic bit m_acc();
        return ifc.lu_valid && (m_q.size() < DEPTH) && (ifc.lu_rd != 5'd0);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_denied <= 0;
        end else begin
            m_denied <= ((m_q.size() != 0) && !m_pop()) ? m_denied + 1 : 0;
            if (m_pop()) begin
                if (m_acc()) m_q.push_back('{rd: ifc.lu_rd, data: ifc.lu_data});
                void'(m_q.pop_front());
            end else if (m_acc()) begin
                m_q.push_back('{rd: ifc.lu_rd, data: ifc.lu_data});
            end
        end
    end

    task automatic drive_wb(input bit v, input logic [4:0] rd, input logic [31:0] d);
        ifc.wb_valid = v; ifc.wb_wen = v; ifc.wb_rd = rd; ifc.wb_data = d;
    endtask
    task automatic drive_lu(input bit v, input logic [4:0] rd, input logic [31:0] d);
        ifc.lu_valid = v; ifc.lu_rd = rd; ifc.lu_data = d;
    endtask
    task automatic idle();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_lu(1'b0, 5'd0, 32'd0);
    endtask
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        drive_wb(1'b1, 5'd3, 32'h1234);
        drive_lu(1'b1, 5'd4, 32'h5678);
        #2;
        checks++; if (ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got=%0b want=0", ifc.rf_wen); end
        checks++; if (ifc.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d want=0", ifc.rf_waddr); end
        checks++; if (ifc.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h want=0", ifc.rf_wdata); end
        checks++; if (ifc.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got=%0b want=0", ifc.wb_stall); end
        checks++; if (ifc.lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got=%0b want=0", ifc.lu_ready); end
        checks++; if (ifc.lu_pending !== 1'b0) begin errors++; $display("FAIL reset_lu_pending got=%0b want=0", ifc.lu_pending); end
        checks++; if (ifc.pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend_mask got=%h want=0", ifc.pend_mask); end
        checks++; if (ifc.fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count got=%0d want=0", ifc.fifo_count); end
        @(negedge clock);
        idle();
        reset = 1'b0;
        #1;
        checks++; if (ifc.lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_lu_ready got=%0b want=1", ifc.lu_ready); end
        next();
    endtask

    task automatic test_single_lu();
        drive_lu(1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clock);
        checks++; if (ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL single_no_bypass rf_wen got=%0b want=0", ifc.rf_wen); end
        next();
        idle();
        @(negedge clock);
        checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin errors++; $display("FAIL single_write got=%0b/%0d/%h want=1/5/deadbeef", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
        checks++; if (ifc.pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend_mask got=%h want=00000020", ifc.pend_mask); end
        next();
        @(negedge clock);
        checks++; if (ifc.lu_pending !== 1'b0 || ifc.rf_wen !== 1'b0)
            begin errors++; $display("FAIL single_drained pending=%0b rf_wen=%0b want=0/0", ifc.lu_pending, ifc.rf_wen); end
        next();
    endtask

    task automatic test_wb_starve();
        logic [4:0]  p_rd[$];
        logic [31:0] p_dat[$];
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        bit          f;
        p_rd = '{5'd9, 5'd12};
        p_dat = '{32'hAAAA0009, 32'hBBBB000C};
        for (int c = 0; c < 12; c++) begin
            drive_wb(1'b1, 5'd3, 32'h3000 + 32'(c));
            if (c == 0)      drive_lu(1'b1, 5'd9, 32'hAAAA0009);
            else if (c == 1) drive_lu(1'b1, 5'd12, 32'hBBBB000C);
            else             drive_lu(1'b0, 5'd0, 32'd0);
            @(negedge clock);
            if (c == 2) begin
                checks++; if (ifc.fifo_count !== 4'd2 || ifc.lu_ready !== 1'b0 || ifc.pend_mask !== 32'h1200)
                    begin errors++; $display("FAIL starve_full count=%0d ready=%0b mask=%h want=2/0/00001200", ifc.fifo_count, ifc.lu_ready, ifc.pend_mask); end
            end
            f = GUARD && (c == 5 || c == 10);
            exp_a = f ? p_rd[0] : 5'd3;
            exp_d = f ? p_dat[0] : 32'h3000 + 32'(c);
            checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata, ifc.wb_stall} !== {1'b1, exp_a, exp_d, f})
                begin errors++; $display("FAIL starve_cyc%0d got=%0b/%0d/%h stall=%0b want=1/%0d/%h stall=%0b", c, ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata, ifc.wb_stall, exp_a, exp_d, f); end
            if (f) begin void'(p_rd.pop_front()); void'(p_dat.pop_front()); end
            next();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (p_rd.size() != 0) begin
                checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, p_rd[0], p_dat[0]})
                    begin errors++; $display("FAIL starve_drain%0d got=%0b/%0d/%h want=1/%0d/%h", k, ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata, p_rd[0], p_dat[0]); end
                void'(p_rd.pop_front()); void'(p_dat.pop_front());
            end else begin
                checks++; if (ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL starve_drain%0d rf_wen got=%0b want=0", k, ifc.rf_wen); end
            end
            next();
        end
    endtask

    task automatic test_rd0_drop();
        drive_lu(1'b1, 5'd0, 32'h00000BAD);
        @(negedge clock);
        checks++; if (ifc.lu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got=%0b want=1", ifc.lu_ready); end
        next();
        idle();
        @(negedge clock);
        checks++; if ({ifc.fifo_count, ifc.rf_wen, ifc.pend_mask} !== {4'd0, 1'b0, 32'd0})
            begin errors++; $display("FAIL rd0_dropped count=%0d rf_wen=%0b mask=%h want=0/0/0", ifc.fifo_count, ifc.rf_wen, ifc.pend_mask); end
        next();
    endtask

    task automatic test_wb_rd0_drain();
        drive_lu(1'b1, 5'd7, 32'h00000077);
        next();
        idle();
        drive_wb(1'b1, 5'd0, 32'h00000055);
        @(negedge clock);
        checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, 5'd7, 32'h77})
            begin errors++; $display("FAIL wbrd0_drain got=%0b/%0d/%h want=1/7/00000077", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
        next();
        idle();
        @(negedge clock);
        checks++; if (ifc.fifo_count !== 4'd0) begin errors++; $display("FAIL wbrd0_empty count=%0d want=0", ifc.fifo_count); end
        next();
    endtask

    task automatic test_full_backpressure();
        drive_wb(1'b1, 5'd3, 32'h100); drive_lu(1'b1, 5'd1, 32'hE1);
        next();
        drive_wb(1'b1, 5'd3, 32'h101); drive_lu(1'b1, 5'd2, 32'hE2);
        next();
        drive_wb(1'b0, 5'd0, 32'd0);   drive_lu(1'b1, 5'd4, 32'hE3);
        @(negedge clock);
        checks++; if ({ifc.lu_ready, ifc.fifo_count, ifc.pend_mask} !== {1'b0, 4'd2, 32'h6})
            begin errors++; $display("FAIL full_held ready=%0b count=%0d mask=%h want=0/2/00000006", ifc.lu_ready, ifc.fifo_count, ifc.pend_mask); end
        checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, 5'd1, 32'hE1})
            begin errors++; $display("FAIL full_w1 got=%0b/%0d/%h want=1/1/000000e1", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
        next();
        @(negedge clock);
        checks++; if (ifc.lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got=%0b want=1", ifc.lu_ready); end
        checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, 5'd2, 32'hE2})
            begin errors++; $display("FAIL full_w2 got=%0b/%0d/%h want=1/2/000000e2", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
        next();
        idle();
        @(negedge clock);
        checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {1'b1, 5'd4, 32'hE3})
            begin errors++; $display("FAIL full_w3 got=%0b/%0d/%h want=1/4/000000e3", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
        next();
        @(negedge clock);
        checks++; if ({ifc.rf_wen, ifc.fifo_count} !== {1'b0, 4'd0})
            begin errors++; $display("FAIL full_empty rf_wen=%0b count=%0d want=0/0", ifc.rf_wen, ifc.fifo_count); end
        next();
    endtask

    task automatic test_async_reset_mid();
        drive_wb(1'b1, 5'd3, 32'h200); drive_lu(1'b1, 5'd6, 32'h66);
        next();
        drive_lu(1'b1, 5'd8, 32'h88);
        next();
        drive_lu(1'b0, 5'd0, 32'd0);
        @(negedge clock);
        checks++; if (ifc.fifo_count !== 4'd2) begin errors++; $display("FAIL arst_pre count=%0d want=2", ifc.fifo_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({ifc.fifo_count, ifc.pend_mask, ifc.rf_wen, ifc.lu_pending} !== {4'd0, 32'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL arst_now count=%0d mask=%h rf_wen=%0b pending=%0b want=0/0/0/0", ifc.fifo_count, ifc.pend_mask, ifc.rf_wen, ifc.lu_pending); end
        idle();
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if ({ifc.rf_wen, ifc.fifo_count} !== {1'b0, 4'd0})
                begin errors++; $display("FAIL arst_stale%0d rf_wen=%0b count=%0d want=0/0", k, ifc.rf_wen, ifc.fifo_count); end
        end
        next();
    endtask

    task automatic test_random();
        bit          pp, wr;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] em;
        for (int n = 0; n < 500; n++) begin
            ifc.wb_valid = ($urandom_range(0, 99) < 60);
            ifc.wb_wen   = ($urandom_range(0, 3) != 0);
            ifc.wb_rd    = 5'($urandom_range(0, 7));
            ifc.wb_data  = $urandom;
            drive_lu($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
            @(negedge clock);
            pp = m_pop();
            wr = m_wb_req();
            ea = pp ? m_q[0].rd : (wr ? ifc.wb_rd : 5'd0);
            ed = pp ? m_q[0].data : (wr ? ifc.wb_data : 32'd0);
            em = 32'd0;
            foreach (m_q[i]) em[m_q[i].rd] = 1'b1;
            checks++; if ({ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata} !== {pp | wr, ea, ed})
                begin errors++; $display("FAIL rand%0d_rf got=%0b/%0d/%h want=%0b/%0d/%h", n, ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata, pp | wr, ea, ed); end
            checks++; if (ifc.wb_stall !== m_forced()) begin errors++; $display("FAIL rand%0d_stall got=%0b want=%0b", n, ifc.wb_stall, m_forced()); end
            checks++; if (ifc.lu_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rand%0d_ready got=%0b want=%0b", n, ifc.lu_ready, m_q.size() < DEPTH); end
            checks++; if (ifc.fifo_count !== 4'(m_q.size())) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", n, ifc.fifo_count, m_q.size()); end
            checks++; if (ifc.pend_mask !== em) begin errors++; $display("FAIL rand%0d_mask got=%h want=%h", n, ifc.pend_mask, em); end
            checks++; if (ifc.lu_pending !== (m_q.size() != 0)) begin errors++; $display("FAIL rand%0d_pending got=%0b want=%0b", n, ifc.lu_pending, m_q.size() != 0); end
            next();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_lu();
        test_wb_starve();
        test_rd0_drop();
        test_wb_rd0_drain();
        test_full_backpressure();
        test_async_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the writeback stage and a long-latency result unit (multiply/divide). Writeback results are written through immediately. Long-latency results are buffered in a small FIFO and drained on cycles when writeback leaves the port idle. An optional starvation guard stalls writeback so the buffered results are guaranteed to drain.

## Interface
Parameters:
- FIFO_DEPTH, 2, long-latency result buffer entries; power of two, 2..8
- STARVE_LIMIT, 4, consecutive denied cycles before the guard forces a drain; 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  writeback slot valid
- wb_wen  in  1  writeback register write enable (already valid-qualified upstream)
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback value
- wb_stall  out  1  hold the writeback stage; it must present the same inputs next cycle
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  arbiter accepts the offered result
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result value
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- lu_pending  out  1  FIFO non-empty
- pend_mask  out  32  bit i set if any FIFO entry targets register xi; read by the hazard unit
- fifo_count  out  4  current occupancy

## Operation
- A writeback request is wb_valid & wb_wen & (wb_rd != 0).
- Enqueue occurs on lu_valid & lu_ready.
  - lu_ready = !full; it is never combinationally dependent on a same-cycle dequeue.
  - An accepted result with lu_rd == 0 is dropped and not enqueued.
- No bypass: an accepted long-latency result always passes through the FIFO.
- Grant is decided combinationally each cycle:
  - Forced (guard active): grant FIFO head, wb_stall = 1.
  - Otherwise, if a writeback request is present: grant writeback; rf_waddr/rf_wdata = wb_rd/wb_data.
  - Otherwise, if the FIFO is non-empty: grant head, dequeue at clock edge.
  - Otherwise: rf_wen = 0.
- Simultaneous enqueue and dequeue is allowed; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a count register, so the full and empty states are unambiguous.
- pend_mask is the OR of one-hot(rd) over valid entries, computed combinationally from storage.
- Ordering between buffered results and younger writeback writes to the same rd is the hazard unit's responsibility, using pend_mask.

## Timing
- Writeback write latency is 0: rf_* reflects wb_* in the same cycle, and the register file captures it at the next edge.
- A long-latency result accepted at edge t can be written at the earliest during cycle t+1.
- Worst-case drain with the guard enabled: FIFO_DEPTH×(STARVE_LIMIT+1) cycles.
- Reset values: rf_wen 0, rf_waddr 0, rf_wdata 0, wb_stall 0, lu_pending 0, pend_mask 0, fifo_count 0, lu_ready 0 while reset is asserted.
- lu_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all buffered results and clears the starvation counter.

## Configuration
- RF_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each cycle where the FIFO is non-empty and the head is not granted.
  - It clears on any dequeue or when the FIFO is empty.
  - When the counter equals STARVE_LIMIT, the forced grant and wb_stall are asserted.
- RF_STARVE_GUARD_EN undefined:
  - The counter is absent and wb_stall is tied 0.
  - Writeback has strict priority, so the long-latency unit can starve while writeback writes every cycle.

## Structure
- Package rf_wr_pkg contains:
  - typedef rf_wr_t {logic [4:0] rd; logic [31:0] data;}
  - localparam RF_ADDR_W = 5
- Sub-module rf_wr_fifo: parameterized storage of rf_wr_t with push/pop/count and an entry-valid vector used for pend_mask. The arbiter instantiates one.

## Test plan
- Idle writeback; lu_valid pulse with rd=5, data=0xDEADBEEF -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; lu_pending returns to 0.
- Writeback request every cycle (rd=3); two long-latency results pushed -> fifo_count=2, lu_ready=0, pend_mask reflects both rd.
  - Guard undefined: rf_waddr stays 3 indefinitely.
  - Guard defined with STARVE_LIMIT=4: wb_stall=1 on the 5th denied cycle and the head is written.
- lu_rd=0 accepted -> no enqueue, fifo_count stays 0, no write.
- Writeback with wb_rd=0 while FIFO holds rd=7 -> FIFO head written to x7 that cycle.
- Full FIFO: one entry dequeued while lu_valid is held -> lu_ready stays 0 that cycle and rises next cycle; no entry lost.
- Reset asserted asynchronously with 2 entries buffered -> fifo_count=0, pend_mask=0, rf_wen=0 immediately; no stale write after release.
